pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit that drives the enable and flush of the decode/execute latch and the fetch stage. It consumes the latched execute-stage fields (destination select, memory flag, jump request and type) plus ALU flags and memory acknowledge, and decides every cycle whether the pipeline advances, stalls or squashes wrong-path instructions. It sits beside the decode/execute latch and closes the handshake that the latch's `en` input expects.

## Interface
- `MEM_TIMEOUT`, 255: maximum MEM_WAIT cycles before abort; 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `dec_valid`  in  1  decode stage holds a valid instruction.
- `dec_selA`  in  6  decode-stage source A select.
- `dec_selB`  in  5  decode-stage source B select.
- `ex_selOut`  in  6  execute-stage destination select; 0 = none.
- `ex_lam_new`  in  1  execute-stage instruction is a memory access.
- `ex_new_jmp`  in  1  execute-stage instruction is a jump.
- `ex_jmp_type`  in  3  condition: 0 never, 1 always, 2 Z, 3 !Z, 4 N, 5 !N, 6 C, 7 !C.
- `flag_z`, `flag_n`, `flag_c`  in  1 each  ALU flags for the execute instruction.
- `mem_ack`  in  1  memory access completes this cycle.
- `fetch_en`  out  1  fetch/PC advance enable.
- `dec_en`  out  1  decode/execute latch enable.
- `dec_flush`  out  1  latch loads NOP (all zero) instead of decode fields.
- `pc_load`  out  1  load PC with jump target this cycle.
- `mem_err`  out  1  one-cycle pulse on memory timeout.
- `stall_cnt`, `flush_cnt`  out  16 each  performance counters (see Configuration).

## Operation
- States: RUN, MEM_WAIT, FLUSH. Reset state RUN; timeout counter 0.
- `taken` = `ex_new_jmp` AND condition(`ex_jmp_type`, flags) true.
- `hazard` = `dec_valid` AND `ex_lam_new` AND `ex_selOut`≠0 AND (`ex_selOut`==`dec_selA` OR `ex_selOut[4:0]`==`dec_selB` with `ex_selOut[5]`=0).
- RUN, priority high→low:
  - `taken`: `pc_load`=1, `dec_en`=1, `dec_flush`=1, `fetch_en`=1; next FLUSH.
  - `ex_lam_new` AND NOT `mem_ack`: all enables 0; next MEM_WAIT, counter←1.
  - `hazard` (memory completing this cycle): `fetch_en`=0, `dec_en`=1, `dec_flush`=1 (bubble); stay RUN.
  - else `fetch_en`=`dec_en`=1, `dec_flush`=0.
- MEM_WAIT: `fetch_en`=`dec_en`=0, latch holds. `mem_ack`=1 → RUN, and RUN rules apply to the now-unchanged execute fields on the next cycle with `ex_lam_new` treated as complete (registered `mem_done` flag set, cleared on next latch advance). Counter==`MEM_TIMEOUT` without ack → `mem_err`=1 for one cycle, `mem_done` set, RUN.
- FLUSH: `fetch_en`=1, `dec_en`=1, `dec_flush`=1, `pc_load`=0; next RUN unconditionally (jumps and memory flags of the flushed slot ignored).
- `ex_jmp_type`=0 with `ex_new_jmp`=1: not taken, no penalty.

## Timing
- All outputs combinational from state and inputs; zero-cycle decision latency.
- Reset asserted: all outputs 0, state RUN, counters 0, `mem_done` 0; effective immediately (asynchronous).
- Reset mid-MEM_WAIT or mid-FLUSH: returns to RUN, no `mem_err`.
- Taken jump penalty: exactly 2 squashed slots (jump cycle + FLUSH cycle).
- Load-use bubble: exactly 1 cycle.
- Memory stall: N cycles for ack arriving N cycles after entry; `mem_ack` same cycle as `ex_lam_new` in RUN → 0 stall.
- `mem_ack` and timeout on the same cycle: ack wins, no `mem_err`.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cnt` increments each cycle with `dec_en`=0 or a load-use bubble; `flush_cnt` increments on each taken jump; both 16-bit saturating at 0xFFFF, cleared by reset.
- Not defined: both outputs tied to 0, no counter registers.

## Test plan
- Straight-line: `dec_valid`=1, no jumps/memory for 10 cycles → `fetch_en`=`dec_en`=1, `dec_flush`=0 every cycle.
- Taken jump: `ex_new_jmp`=1, type 2, `flag_z`=1 → `pc_load`=1 that cycle, `dec_flush`=1 that cycle and next, then RUN; type 3 with `flag_z`=1 → no flush.
- Memory stall: `ex_lam_new`=1, `mem_ack` after 3 cycles → `dec_en`=0 for 3 cycles, resume on the 4th; ack same cycle → 0 stalls.
- Load-use: `ex_lam_new`=1, `mem_ack`=1, `ex_selOut`=5, `dec_selA`=5 → one cycle `fetch_en`=0, `dec_flush`=1; `ex_selOut`=0 → no bubble.
- Timeout: `MEM_TIMEOUT`=4, no ack → `mem_err` pulses once after 4 stall cycles, state RUN; reset asserted in MEM_WAIT → outputs 0 immediately, no `mem_err`.
- With `PIPE_CTRL_PERF_EN`: 2 taken jumps + 3-cycle memory stall → `flush_cnt`=2, `stall_cnt`=3.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control for the decode/execute latch and the fetch stage: advance, stall or squash every cycle.
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dec_valid,
  input  logic [5:0]  dec_selA,
  input  logic [4:0]  dec_selB,
  input  logic [5:0]  ex_selOut,
  input  logic        ex_lam_new,
  input  logic        ex_new_jmp,
  input  logic [2:0]  ex_jmp_type,
  input  logic        flag_z,
  input  logic        flag_n,
  input  logic        flag_c,
  input  logic        mem_ack,
  output logic        fetch_en,
  output logic        dec_en,
  output logic        dec_flush,
  output logic        pc_load,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t     state;
  logic [7:0] to_cnt;
  logic       mem_done;

  logic cond;
  logic taken;
  logic hazard;
  logic mem_pending;
  logic timeout_hit;

  always_comb begin
    cond = 1'b0;
    case (ex_jmp_type)
      3'd0: cond = 1'b0;
      3'd1: cond = 1'b1;
      3'd2: cond = flag_z;
      3'd3: cond = ~flag_z;
      3'd4: cond = flag_n;
      3'd5: cond = ~flag_n;
      3'd6: cond = flag_c;
      3'd7: cond = ~flag_c;
      default: cond = 1'b0;
    endcase
  end

  // mem_done masks a load already finished in MEM_WAIT while its fields sit unchanged in the latch
  assign taken       = ex_new_jmp & cond;
  assign mem_pending = ex_lam_new & ~mem_ack & ~mem_done;
  assign timeout_hit = (to_cnt == TIMEOUT_VAL);
  assign hazard      = dec_valid & ex_lam_new & (ex_selOut != 6'd0) &
                       ((ex_selOut == dec_selA) |
                        (~ex_selOut[5] & (ex_selOut[4:0] == dec_selB)));

  // Outputs are forced low while reset is held so the effect is immediate
  always_comb begin
    fetch_en  = 1'b0;
    dec_en    = 1'b0;
    dec_flush = 1'b0;
    pc_load   = 1'b0;
    mem_err   = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (taken) begin
            pc_load   = 1'b1;
            fetch_en  = 1'b1;
            dec_en    = 1'b1;
            dec_flush = 1'b1;
          end else if (mem_pending) begin
            fetch_en = 1'b0;
          end else if (hazard) begin
            dec_en    = 1'b1;
            dec_flush = 1'b1;
          end else begin
            fetch_en = 1'b1;
            dec_en   = 1'b1;
          end
        end
        MEM_WAIT: mem_err = ~mem_ack & timeout_hit;
        FLUSH: begin
          fetch_en  = 1'b1;
          dec_en    = 1'b1;
          dec_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      to_cnt   <= 8'd0;
      mem_done <= 1'b0;
    end else begin
      if (dec_en) mem_done <= 1'b0;
      case (state)
        RUN: begin
          if (taken) begin
            state <= FLUSH;
          end else if (mem_pending) begin
            state  <= MEM_WAIT;
            to_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack || timeout_hit) begin
            state    <= RUN;
            mem_done <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        FLUSH: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;
  logic        stall_evt;

  // A load-use bubble is the only cycle with the latch advancing a NOP while fetch is held
  assign stall_evt = ~dec_en | (dec_flush & ~fetch_en);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      if (stall_evt && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (pc_load && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed test-plan sequences, then randomized traffic through an emulated latch.
// Expected responses come from a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic        clk, reset, dec_valid;
  logic [5:0]  dec_selA;
  logic [4:0]  dec_selB;
  logic [5:0]  ex_selOut;
  logic        ex_lam_new, ex_new_jmp;
  logic [2:0]  ex_jmp_type;
  logic        flag_z, flag_n, flag_c, mem_ack;
  logic        fetch_en, dec_en, dec_flush, pc_load, mem_err;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_selA(dec_selA), .dec_selB(dec_selB),
    .ex_selOut(ex_selOut), .ex_lam_new(ex_lam_new), .ex_new_jmp(ex_new_jmp), .ex_jmp_type(ex_jmp_type),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .mem_ack(mem_ack),
    .fetch_en(fetch_en), .dec_en(dec_en), .dec_flush(dec_flush), .pc_load(pc_load), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    bit dv; bit [5:0] sa; bit [4:0] sb; bit [5:0] so;
    bit lam; bit jmp; bit [2:0] jt; bit z; bit n; bit c; bit ack;
  } stim_t;

  // ctl = {pc_load, fetch_en, dec_en, dec_flush, mem_err}
  typedef struct { bit [4:0] ctl; bit [15:0] sc; bit [15:0] fc; int cyc; } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: what the coming cycle is (squash slot / waiting on memory / normal) plus tallies
  bit m_squash_slot, m_waiting, m_load_done;
  int m_wait_age, m_stalls, m_flushes;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t mk(bit dv, bit [5:0] sa, bit [4:0] sb, bit [5:0] so, bit lam,
                               bit jmp, bit [2:0] jt, bit z, bit n, bit c, bit ack);
    stim_t s;
    s.dv = dv; s.sa = sa; s.sb = sb; s.so = so; s.lam = lam; s.jmp = jmp;
    s.jt = jt; s.z = z; s.n = n; s.c = c; s.ack = ack;
    return s;
  endfunction

  task automatic modelStep(input bit rst, input stim_t s, output exp_t e);
    bit [7:0] cond_tab;
    bit uses_load, stall_ev;
    e.ctl = 5'b0;
    e.sc = 16'(m_stalls);
    e.fc = 16'(m_flushes);
    stall_ev = 1'b0;
    cond_tab = {~s.c, s.c, ~s.n, s.n, ~s.z, s.z, 1'b1, 1'b0};
    uses_load = s.dv && s.lam && s.so != 0 && (s.so == s.sa || (!s.so[5] && s.so[4:0] == s.sb));
    if (rst) begin
      e.sc = 0; e.fc = 0;
      m_squash_slot = 0; m_waiting = 0; m_load_done = 0; m_wait_age = 0;
      m_stalls = 0; m_flushes = 0;
    end else if (m_squash_slot) begin
      e.ctl = 5'b01110;
      m_squash_slot = 0; m_load_done = 0;
    end else if (m_waiting) begin
      m_wait_age++;
      stall_ev = 1'b1;
      if (s.ack) begin
        m_waiting = 0; m_load_done = 1;
      end else if (m_wait_age == TO) begin
        e.ctl = 5'b00001;
        m_waiting = 0; m_load_done = 1;
      end
    end else if (s.jmp && cond_tab[s.jt]) begin
      e.ctl = 5'b11110;
      m_squash_slot = 1; m_load_done = 0; m_flushes++;
    end else if (s.lam && !s.ack && !m_load_done) begin
      m_waiting = 1; m_wait_age = 0; stall_ev = 1'b1;
    end else if (uses_load) begin
      e.ctl = 5'b00110;
      stall_ev = 1'b1; m_load_done = 0;
    end else begin
      e.ctl = 5'b01100;
      m_load_done = 0;
    end
    if (stall_ev && m_stalls < 65535) m_stalls++;
`ifndef PIPE_CTRL_PERF_EN
    e.sc = 0;
    e.fc = 0;
`endif
  endtask

  task automatic applyStimulus(input bit rst, input stim_t s, output exp_t e);
    @(posedge clk);
    #1;
    reset = rst; dec_valid = s.dv; dec_selA = s.sa; dec_selB = s.sb; ex_selOut = s.so;
    ex_lam_new = s.lam; ex_new_jmp = s.jmp; ex_jmp_type = s.jt;
    flag_z = s.z; flag_n = s.n; flag_c = s.c; mem_ack = s.ack;
    modelStep(rst, s, e);
    e.cyc = cyc;
    cyc++;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    bit [4:0] act;
    act = {pc_load, fetch_en, dec_en, dec_flush, mem_err};
    checks++;
    if (act !== e.ctl) begin
      failures++;
      $display("[TB] FAIL ctl cyc=%0d pc_load/fetch/dec/flush/err got=%b want=%b", e.cyc, act, e.ctl);
    end
    checks++;
    if (stall_cnt !== e.sc) begin
      failures++;
      $display("[TB] FAIL stall_cnt cyc=%0d got=%0d want=%0d", e.cyc, stall_cnt, e.sc);
    end
    checks++;
    if (flush_cnt !== e.fc) begin
      failures++;
      $display("[TB] FAIL flush_cnt cyc=%0d got=%0d want=%0d", e.cyc, flush_cnt, e.fc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic bit [5:0] randSel();
    case ($urandom_range(0, 6))
      0: return 6'd0;
      1: return 6'd1;
      2: return 6'd2;
      3: return 6'd3;
      4: return 6'd5;
      5: return 6'd33;
      default: return 6'd34;
    endcase
  endfunction

  initial begin
    exp_t e;
    stim_t s, idle, ld;
    bit rst;
    bit [5:0] l_so, d_so, d_sa;
    bit l_lam, l_jmp, d_lam, d_jmp, d_dv;
    bit [2:0] l_jt, d_jt;
    bit [4:0] d_sb;

    reset = 1'b1; dec_valid = 0; dec_selA = 0; dec_selB = 0; ex_selOut = 0; ex_lam_new = 0;
    ex_new_jmp = 0; ex_jmp_type = 0; flag_z = 0; flag_n = 0; flag_c = 0; mem_ack = 0;
    idle = mk(1, 6'd1, 5'd2, 6'd0, 0, 0, 3'd0, 0, 0, 0, 0);

    repeat (2) applyStimulus(1, idle, e);
    for (int i = 0; i < 10; i++) applyStimulus(0, mk(1, 6'(i), 5'(i + 1), 6'd0, 0, 0, 3'd0, 0, 0, 0, 0), e);

    $display("[TB] taken jump, not-taken jump, never-type jump");
    applyStimulus(0, mk(1, 6'd1, 5'd2, 6'd9, 0, 1, 3'd2, 1, 0, 0, 0), e);
    applyStimulus(0, mk(1, 6'd1, 5'd2, 6'd0, 1, 1, 3'd1, 0, 0, 0, 0), e);
    applyStimulus(0, idle, e);
    applyStimulus(0, mk(1, 6'd1, 5'd2, 6'd9, 0, 1, 3'd3, 1, 0, 0, 0), e);
    applyStimulus(0, mk(1, 6'd1, 5'd2, 6'd9, 0, 1, 3'd0, 1, 1, 1, 0), e);
    applyStimulus(0, idle, e);

    $display("[TB] memory stall with ack in third cycle, then same-cycle ack");
    ld = mk(1, 6'd1, 5'd2, 6'd7, 1, 0, 3'd0, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, ld, e);
    ld.ack = 1; applyStimulus(0, ld, e);
    ld.ack = 0; applyStimulus(0, ld, e);
    ld.ack = 1; applyStimulus(0, ld, e);
    applyStimulus(0, idle, e);

    $display("[TB] load-use bubbles");
    applyStimulus(0, mk(1, 6'd5, 5'd3, 6'd5, 1, 0, 3'd0, 0, 0, 0, 1), e);
    applyStimulus(0, mk(1, 6'd5, 5'd3, 6'd0, 0, 0, 3'd0, 0, 0, 0, 0), e);
    applyStimulus(0, mk(1, 6'd0, 5'd0, 6'd0, 1, 0, 3'd0, 0, 0, 0, 1), e);
    applyStimulus(0, mk(1, 6'd1, 5'd3, 6'd3, 1, 0, 3'd0, 0, 0, 0, 1), e);
    applyStimulus(0, mk(1, 6'd1, 5'd3, 6'd35, 1, 0, 3'd0, 0, 0, 0, 1), e);
    applyStimulus(0, mk(0, 6'd5, 5'd3, 6'd5, 1, 0, 3'd0, 0, 0, 0, 1), e);

    $display("[TB] timeout, ack on timeout cycle, reset on timeout cycle");
    ld.ack = 0;
    repeat (5) applyStimulus(0, ld, e);
    applyStimulus(0, ld, e);
    applyStimulus(0, idle, e);
    repeat (4) applyStimulus(0, ld, e);
    ld.ack = 1; applyStimulus(0, ld, e);
    ld.ack = 0; applyStimulus(0, ld, e);
    repeat (4) applyStimulus(0, ld, e);
    applyStimulus(1, ld, e);
    applyStimulus(0, idle, e);

    $display("[TB] two taken jumps plus three-cycle stall from reset");
    applyStimulus(1, idle, e);
    repeat (2) begin
      applyStimulus(0, mk(1, 6'd1, 5'd2, 6'd0, 0, 1, 3'd7, 0, 0, 0, 0), e);
      applyStimulus(0, idle, e);
    end
    ld.ack = 0;
    repeat (2) applyStimulus(0, ld, e);
    ld.ack = 1; applyStimulus(0, ld, e);
    repeat (2) applyStimulus(0, idle, e);

    $display("[TB] randomized traffic");
    l_so = 0; l_lam = 0; l_jmp = 0; l_jt = 0;
    d_dv = 1; d_sa = 1; d_sb = 2; d_so = 0; d_lam = 0; d_jmp = 0; d_jt = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      s = mk(d_dv, d_sa, d_sb, l_so, l_lam, l_jmp, l_jt, 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) < 4));
      applyStimulus(rst, s, e);
      if (rst) begin
        l_so = 0; l_lam = 0; l_jmp = 0; l_jt = 0;
      end else if (e.ctl[2]) begin
        if (e.ctl[1]) begin
          l_so = 0; l_lam = 0; l_jmp = 0; l_jt = 0;
        end else begin
          l_so = d_so; l_lam = d_lam; l_jmp = d_jmp; l_jt = d_jt;
        end
      end
      if (rst || e.ctl[3]) begin
        d_dv = ($urandom_range(0, 7) != 0);
        d_sa = randSel();
        d_sb = 5'($urandom_range(0, 5));
        d_so = randSel();
        d_lam = ($urandom_range(0, 2) == 0);
        d_jmp = ($urandom_range(0, 4) == 0);
        d_jt = 3'($urandom_range(0, 7));
      end
    end
    applyStimulus(0, idle, e);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
